encoder_8_3_seq: RTL and testbench
==================================

ENCODER_8_3_SEQ -- requirements
Module: encoder_8_3_seq

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1: 1 = emit lowest set index first, 0 = emit highest first.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port in_vec  input  8  request vector, multi-hot allowed.
REQ-005 The block SHALL have port in_valid  input  1  in_vec is valid this cycle.
REQ-006 The block SHALL have port in_ready  output  1  block can accept in_vec this cycle.
REQ-007 The block SHALL have port out_code  output  3  binary index of the currently presented set bit.
REQ-008 The block SHALL have port out_last  output  1  out_code is the final code for the accepted vector.
REQ-009 The block SHALL have port out_valid  output  1  out_code/out_last are valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts out_code this cycle.
REQ-011 The block SHALL have port zero_in  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-012 The block SHALL implement two states: IDLE and EMIT.
REQ-013 IDLE: in_ready SHALL be 1, out_valid 0; accept = in_valid & in_ready.
REQ-014 On accept with in_vec != 0, the block SHALL latch in_vec into an 8-bit pending register and enter EMIT on the next edge.
REQ-015 On accept with in_vec == 0, the block SHALL stay in IDLE, emit no code, and assert zero_in for exactly the following cycle.
REQ-016 EMIT: in_ready SHALL be 0; out_valid SHALL be 1; in_valid SHALL be ignored.
REQ-017 out_code SHALL be the lowest set index of pending when LSB_FIRST=1, the highest when LSB_FIRST=0.
REQ-018 out_last SHALL be 1 exactly when pending has one bit set.
REQ-019 Latency: the first code SHALL be valid the cycle after accept.
REQ-020 On out_valid & out_ready, the presented bit SHALL be cleared from pending at that edge.
REQ-021 If the handshaken code had out_last=1, the block SHALL return to IDLE with in_ready=1 in the next cycle; no same-cycle re-accept.
REQ-022 With out_ready held at 1, the block SHALL deliver one code per cycle.
REQ-023 While out_valid & !out_ready, out_code, out_last and pending SHALL stay stable.
REQ-024 Each set bit SHALL be emitted exactly once, in strict priority order; the number of codes SHALL equal popcount(in_vec).

Reset
REQ-025 When rst_n=0 at a clk edge, the block SHALL set state=IDLE, pending=0, out_code=0, out_last=0, out_valid=0, zero_in=0; in_ready SHALL be 1 from the following cycle.
REQ-026 Reset during EMIT SHALL discard all remaining pending codes, with no partial output afterward.
REQ-027 Reset SHALL override any handshake occurring in the same cycle.

Structure
REQ-028 Shared package encoder_pkg SHALL hold VEC_W=8, CODE_W=3 and the state enum {IDLE, EMIT}.
REQ-029 Bit selection SHALL be a combinational sub-module prio_enc_8_3 (in: 8-bit vector, LSB_FIRST; out: 3-bit index, one-bit any-set).
REQ-030 Only the state, pending and zero_in SHALL be registered; outputs derive from them.

Verification
REQ-031 LSB_FIRST=1, in_vec=8'b1010_0100, out_ready=1 -> codes 2,5,7 on three consecutive cycles, out_last only on 7, in_ready=1 the cycle after.
REQ-032 LSB_FIRST=0, in_vec=8'hFF, out_ready=1 -> codes 7..0 on cycles 1-8 after accept, in_ready=1 at cycle 9.
REQ-033 in_vec=8'b0001_0000, out_ready=0 for 3 cycles then 1 -> code 4, last=1 held stable for 4 cycles, one transfer.
REQ-034 in_vec=8'h00 accepted -> zero_in pulses 1 cycle, out_valid stays 0, in_ready stays 1.
REQ-035 in_vec=8'hC3, rst_n=0 after first code -> outputs at reset values, no further codes, next vector 8'h01 yields single code 0 with last=1.
REQ-036 in_valid held with new vector during EMIT -> ignored; only after in_ready returns high is it accepted.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared widths, state type and small helpers for the sequential 8:3 encoder.
package encoder_pkg;

    localparam int unsigned VEC_W  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // True when exactly one bit of v is set.
    function automatic logic is_single(input logic [VEC_W-1:0] v);
        return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
    endfunction

    // Binary index to one-hot mask.
    function automatic logic [VEC_W-1:0] code_mask(input logic [CODE_W-1:0] c);
        return VEC_W'(1) << c;
    endfunction

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational priority encoder: index of the lowest (or highest) set bit.
module prio_enc_8_3
    import encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [VEC_W-1:0]  vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              any_o
);

    // Scan bits; first hit wins for LSB-first, last hit wins for MSB-first.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < int'(VEC_W); i++) begin
            if (vec_i[i]) begin
                if (!LSB_FIRST || !any_o) begin
                    idx_o = CODE_W'(i);
                end
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_8_3_seq.sv
// Sequential 8:3 encoder: accepts a multi-hot vector and emits the index of each
// set bit, one per handshake, in priority order.
module encoder_8_3_seq
    import encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VEC_W-1:0]  in_vec,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              zero_in
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   pending_q, pending_d;
    logic               zero_in_q, zero_in_d;
    logic [CODE_W-1:0]  sel_code;
    logic               sel_any;
    logic               accept;
    logic               xfer;

    prio_enc_8_3 #(
        .LSB_FIRST (LSB_FIRST)
    ) u_prio (
        .vec_i (pending_q),
        .idx_o (sel_code),
        .any_o (sel_any)
    );

    // Outputs derive purely from registered state; pending is zero outside EMIT.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        out_code  = sel_code;
        out_last  = is_single(pending_q);
        zero_in   = zero_in_q;
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
    end

    // Next-state: latch non-zero vectors, strip each handshaken bit, exit on last.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_in_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        state_d   = EMIT;
                    end else begin
                        zero_in_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    pending_d = pending_q & ~code_mask(sel_code);
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // sel_any is implied by EMIT; kept for a defined fallback on corruption.
        if (state_q == EMIT && !sel_any) begin
            state_d = IDLE;
        end
    end

    // State registers with synchronous active-low reset overriding any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_in_q <= zero_in_d;
        end
    end

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Directed bench for encoder_8_3_seq: one LSB-first and one MSB-first instance
// share the same stimulus.
module tb_encoder_8_3_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_l, out_last_l, out_valid_l, zero_in_l;
    logic [2:0] out_code_l;
    logic       in_ready_m, out_last_m, out_valid_m, zero_in_m;
    logic [2:0] out_code_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    encoder_8_3_seq #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .out_code  (out_code_l),
        .out_last  (out_last_l),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .zero_in   (zero_in_l)
    );

    encoder_8_3_seq #(.LSB_FIRST(1'b0)) u_dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .out_code  (out_code_m),
        .out_last  (out_last_m),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .zero_in   (zero_in_m)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and checks land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lsb(input string tag, input logic v, input logic [2:0] c,
                             input logic l, input logic r);
        check_eq({tag, ".valid"}, 32'(out_valid_l), 32'(v));
        check_eq({tag, ".ready"}, 32'(in_ready_l), 32'(r));
        if (v) begin
            check_eq({tag, ".code"}, 32'(out_code_l), 32'(c));
            check_eq({tag, ".last"}, 32'(out_last_l), 32'(l));
        end
    endtask

    initial begin
        logic [2:0] exp_lsb [4];
        rst_n     = 1'b0;
        in_vec    = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        // Reset values
        check_eq("rst.in_ready",  32'(in_ready_l),  32'd1);
        check_eq("rst.out_valid", 32'(out_valid_l), 32'd0);
        check_eq("rst.out_code",  32'(out_code_l),  32'd0);
        check_eq("rst.out_last",  32'(out_last_l),  32'd0);
        check_eq("rst.zero_in",   32'(zero_in_l),   32'd0);
        rst_n = 1'b1;
        tick();

        // 1010_0100 LSB-first: 2,5,7; MSB instance starts with 7
        in_vec = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_lsb("a4.c1", 1'b1, 3'd2, 1'b0, 1'b0);
        check_eq("a4.msb.code", 32'(out_code_m), 32'd7);
        check_eq("a4.msb.last", 32'(out_last_m), 32'd0);
        tick();
        check_lsb("a4.c2", 1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        check_lsb("a4.c3", 1'b1, 3'd7, 1'b1, 1'b0);
        tick();
        check_lsb("a4.done", 1'b0, 3'd0, 1'b0, 1'b1);

        // FF on MSB-first instance: 7..0 then ready at cycle 9
        in_vec = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("ff.c%0d.code", k), 32'(out_code_m), 32'(7 - k));
            check_eq($sformatf("ff.c%0d.last", k), 32'(out_last_m), 32'(k == 7));
            check_eq($sformatf("ff.c%0d.valid", k), 32'(out_valid_m), 32'd1);
            tick();
        end
        check_eq("ff.ready9", 32'(in_ready_m), 32'd1);
        check_eq("ff.valid9", 32'(out_valid_m), 32'd0);

        // 0001_0000 with backpressure for 3 cycles
        in_vec = 8'b0001_0000; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_lsb($sformatf("bp.hold%0d", k), 1'b1, 3'd4, 1'b1, 1'b0);
            tick();
        end
        check_lsb("bp.hold3", 1'b1, 3'd4, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        check_lsb("bp.done", 1'b0, 3'd0, 1'b0, 1'b1);

        // Zero vector
        in_vec = 8'h00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("zero.pulse", 32'(zero_in_l), 32'd1);
        check_lsb("zero.c1", 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        check_eq("zero.clear", 32'(zero_in_l), 32'd0);
        check_lsb("zero.c2", 1'b0, 3'd0, 1'b0, 1'b1);

        // C3 with reset after first code
        in_vec = 8'hC3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_lsb("c3.c1", 1'b1, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("c3.rst.valid", 32'(out_valid_l), 32'd0);
        check_eq("c3.rst.code",  32'(out_code_l),  32'd0);
        check_eq("c3.rst.last",  32'(out_last_l),  32'd0);
        check_eq("c3.rst.zero",  32'(zero_in_l),   32'd0);
        tick();
        check_lsb("c3.after", 1'b0, 3'd0, 1'b0, 1'b1);
        in_vec = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_lsb("c3.next", 1'b1, 3'd0, 1'b1, 1'b0);
        tick();
        check_lsb("c3.idle", 1'b0, 3'd0, 1'b0, 1'b1);

        // New vector held during EMIT is ignored until ready returns
        exp_lsb = '{3'd1, 3'd2, 3'd7, 3'd0};
        in_vec = 8'h06; in_valid = 1'b1;
        tick();
        in_vec = 8'h80;
        check_lsb("hold.c1", 1'b1, exp_lsb[0], 1'b0, 1'b0);
        tick();
        check_lsb("hold.c2", 1'b1, exp_lsb[1], 1'b1, 1'b0);
        tick();
        check_lsb("hold.idle", 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check_lsb("hold.new", 1'b1, exp_lsb[2], 1'b1, 1'b0);
        tick();
        check_lsb("hold.end", 1'b0, 3'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
